dmem_port_ctrl: RTL

Single-ported data-memory sequencer between the load unit, the one-entry store buffer and the data memory. Arbitrates the shared port between load requests and committed stores, holds each request stable until the memory responds, and pops the store buffer once a store is written. Blocks loads that alias a buffered store so no stale data is returned. Guarantees stores forward progress with a starvation counter.

---
 rtl/dmem_port_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_port_ctrl.sv
// Single-port data-memory sequencer: arbitrates loads against committed stores,
// blocks loads aliasing the buffered store, and bounds store starvation.
module dmem_port_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W/8-1:0] ld_rmask,
  output logic                ld_gnt,
  output logic                ld_resp_valid,
  output logic [DATA_W-1:0]   ld_rdata,
  input  logic                sb_valid,
  input  logic [ADDR_W-1:0]   sb_addr,
  input  logic [DATA_W-1:0]   sb_wdata,
  input  logic [DATA_W/8-1:0] sb_wmask,
  input  logic                rob_commit_store,
  output logic                sb_pop,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_rmask,
  output logic [DATA_W/8-1:0] dmem_wmask,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_resp
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

  state_t        state;
  logic          committed;
  logic          cancel;
  logic [CW-1:0] starve_cnt;

  logic blocked;
  logic ld_elig;
  logic st_elig;
  logic starve_max;
  logic store_wins;
  logic st_gnt;
  logic unused_addr_bits;

  // Byte offsets never reach the word-aligned port.
  assign unused_addr_bits = ^{ld_addr[1:0], sb_addr[1:0]};

  // Word-granular alias check against any buffered store, committed or not.
  assign blocked    = sb_valid && (sb_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
  assign ld_elig    = ld_req && !blocked && !flush;
  assign st_elig    = sb_valid && committed;
  assign starve_max = (starve_cnt == CW'(STARVE_LIMIT));
  assign store_wins = st_elig && (!ld_elig || starve_max);
  assign ld_gnt     = !rst && (state == IDLE) && ld_elig && !store_wins;
  assign st_gnt     = !rst && (state == IDLE) && store_wins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      committed     <= 1'b0;
      cancel        <= 1'b0;
      starve_cnt    <= '0;
      ld_resp_valid <= 1'b0;
      ld_rdata      <= '0;
      sb_pop        <= 1'b0;
      dmem_addr     <= '0;
      dmem_rmask    <= '0;
      dmem_wmask    <= '0;
      dmem_wdata    <= '0;
    end else begin
      ld_resp_valid <= 1'b0;
      sb_pop        <= 1'b0;

      if (!st_elig || st_gnt) begin
        starve_cnt <= '0;
      end else if (ld_gnt && !starve_max) begin
        starve_cnt <= starve_cnt + CW'(1);
      end

      // The completing write retires the entry still shown on sb_valid.
      if (state == STORE_WAIT && dmem_resp) begin
        committed <= 1'b0;
      end else if (rob_commit_store && sb_valid) begin
        committed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ld_gnt) begin
            dmem_addr  <= {ld_addr[ADDR_W-1:2], 2'b00};
            dmem_rmask <= ld_rmask;
            dmem_wmask <= '0;
            cancel     <= 1'b0;
            state      <= LOAD_WAIT;
          end else if (st_gnt) begin
            dmem_addr  <= {sb_addr[ADDR_W-1:2], 2'b00};
            dmem_rmask <= '0;
            dmem_wmask <= sb_wmask;
            dmem_wdata <= sb_wdata;
            state      <= STORE_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (dmem_resp) begin
            if (!(cancel || flush)) begin
              ld_resp_valid <= 1'b1;
              ld_rdata      <= dmem_rdata;
            end
            dmem_rmask <= MW'(0);
            dmem_wmask <= MW'(0);
            cancel     <= 1'b0;
            state      <= IDLE;
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        STORE_WAIT: begin
          if (dmem_resp) begin
            sb_pop     <= 1'b1;
            dmem_rmask <= MW'(0);
            dmem_wmask <= MW'(0);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
